// File: rtl/nios2_qsys_0_oci_dct_ctrl.sv
// Trace-atom packing controller: packs 2-bit atoms into a 15-slot buffer and
// hands full or flushed buffers downstream as framed words; sequences the end-of-test drain.
module nios2_qsys_0_oci_dct_ctrl #(
    parameter int ATOM_W = 2,
    parameter int SLOTS  = 15,
    parameter int CNT_W  = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             atom_valid,
    input  logic [ATOM_W-1:0]                atom,
    output logic                             atom_ready,
    input  logic                             flush,
    input  logic                             test_ending,
    output logic                             frame_valid,
    input  logic                             frame_ready,
    output logic [CNT_W+ATOM_W*SLOTS-1:0]    frame_data,
    output logic [ATOM_W*SLOTS-1:0]          dct_buffer,
    output logic [CNT_W-1:0]                 dct_count,
    output logic                             overflow,
    output logic                             test_has_ended
);

    localparam int                BUF_W    = ATOM_W * SLOTS;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(SLOTS);

    typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

    state_t             state_reg;
    logic               flush_pend_reg;
    logic               accept;
    logic               slot_free;
    logic               xfer;
    logic [CNT_W-1:0]   nxt_count;
    logic [BUF_W-1:0]   nxt_buf;

    assign atom_ready = (state_reg == FILL) && (dct_count != FULL_CNT);
    assign accept     = atom_valid && atom_ready;
    assign nxt_count  = dct_count + CNT_W'(accept);
    assign slot_free  = !frame_valid || frame_ready;

    // The atom accepted this cycle is merged in before any transfer, so a
    // flush or the 15th atom carries it in the emitted frame.
    genvar gi;
    generate
        for (gi = 0; gi < SLOTS; gi++) begin : g_slot
            assign nxt_buf[gi*ATOM_W +: ATOM_W] =
                (accept && (dct_count == CNT_W'(gi))) ? atom : dct_buffer[gi*ATOM_W +: ATOM_W];
        end
    endgenerate

    assign xfer = slot_free && (nxt_count != '0) &&
                  ((nxt_count == FULL_CNT) || flush || flush_pend_reg || (state_reg == DRAIN));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= FILL;
            flush_pend_reg <= 1'b0;
            dct_buffer     <= '0;
            dct_count      <= '0;
            frame_valid    <= 1'b0;
            frame_data     <= '0;
            overflow       <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            if (xfer) begin
                frame_data     <= {nxt_count, nxt_buf};
                frame_valid    <= 1'b1;
                dct_buffer     <= '0;
                dct_count      <= '0;
                flush_pend_reg <= 1'b0;
            end else begin
                dct_buffer <= nxt_buf;
                dct_count  <= nxt_count;
                if (frame_valid && frame_ready)
                    frame_valid <= 1'b0;
                // A flush of an empty buffer is dropped rather than remembered.
                if (flush && (nxt_count != '0))
                    flush_pend_reg <= 1'b1;
            end

            if ((state_reg == FILL) && atom_valid && !atom_ready)
                overflow <= 1'b1;

            case (state_reg)
                FILL: begin
                    if (test_ending)
                        state_reg <= DRAIN;
                end
                DRAIN: begin
                    if ((dct_count == '0) && !frame_valid) begin
                        state_reg      <= DONE;
                        test_has_ended <= 1'b1;
                    end
                end
                default: state_reg <= DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_qsys_0_oci_dct_ctrl.sv
// Directed bench for the DCT packing controller: fill, flush, backpressure,
// overflow, asynchronous reset and end-of-test drain.
module tb_nios2_qsys_0_oci_dct_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        atom_valid;
    logic [1:0]  atom;
    logic        atom_ready;
    logic        flush;
    logic        test_ending;
    logic        frame_valid;
    logic        frame_ready;
    logic [33:0] frame_data;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow;
    logic        test_has_ended;

    int n_assert = 0;
    int n_fail   = 0;

    logic [29:0] exp_buf;
    logic [29:0] exp_buf2;

    always #5 clk = ~clk;

    nios2_qsys_0_oci_dct_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .atom_valid     (atom_valid),
        .atom           (atom),
        .atom_ready     (atom_ready),
        .flush          (flush),
        .test_ending    (test_ending),
        .frame_valid    (frame_valid),
        .frame_ready    (frame_ready),
        .frame_data     (frame_data),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow       (overflow),
        .test_has_ended (test_has_ended)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        atom_valid  = 1'b0;
        atom        = 2'd0;
        flush       = 1'b0;
        test_ending = 1'b0;
        frame_ready = 1'b1;

        // Reset state
        #2;
        chk("rst_frame_valid", 64'(frame_valid), 64'd0);
        chk("rst_frame_data", 64'(frame_data), 64'd0);
        chk("rst_count", 64'(dct_count), 64'd0);
        chk("rst_buffer", 64'(dct_buffer), 64'd0);
        chk("rst_atom_ready", 64'(atom_ready), 64'd1);
        chk("rst_ended", 64'(test_has_ended), 64'd0);
        #10;
        reset_n = 1'b1;
        step();

        // Full frame of 15 atoms, pattern k%4
        exp_buf = '0;
        for (int k = 0; k < 15; k++) begin
            atom_valid = 1'b1;
            atom       = 2'(k % 4);
            exp_buf[2*k +: 2] = 2'(k % 4);
            step();
            if (k == 2) begin
                chk("fill3_count", 64'(dct_count), 64'd3);
                chk("fill3_buffer", 64'(dct_buffer), 64'h24);
            end
        end
        atom_valid = 1'b0;
        chk("full_valid", 64'(frame_valid), 64'd1);
        chk("full_cnt_field", 64'(frame_data[33:30]), 64'd15);
        chk("full_buf_field", 64'(frame_data[29:0]), 64'(exp_buf));
        chk("full_count_clr", 64'(dct_count), 64'd0);
        step();
        chk("full_handshake", 64'(frame_valid), 64'd0);

        // Partial frame via flush
        for (int k = 1; k <= 3; k++) begin
            atom_valid = 1'b1;
            atom       = 2'(k);
            step();
        end
        atom_valid = 1'b0;
        chk("part_count", 64'(dct_count), 64'd3);
        chk("part_buffer", 64'(dct_buffer), 64'h39);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_valid", 64'(frame_valid), 64'd1);
        chk("flush_data", 64'(frame_data), 64'h0C0000039);
        chk("flush_count_clr", 64'(dct_count), 64'd0);
        step();
        chk("flush_handshake", 64'(frame_valid), 64'd0);

        // Flush of an empty buffer: no frame and nothing left pending
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("empty_flush_valid", 64'(frame_valid), 64'd0);
        atom_valid = 1'b1;
        atom       = 2'd2;
        step();
        atom_valid = 1'b0;
        chk("no_pend_valid", 64'(frame_valid), 64'd0);
        chk("no_pend_count", 64'(dct_count), 64'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("single_flush_data", 64'(frame_data), 64'h040000002);
        step();

        // Backpressure: 30 atoms with frame_ready low
        frame_ready = 1'b0;
        exp_buf  = '0;
        exp_buf2 = '0;
        for (int k = 0; k < 30; k++) begin
            atom_valid = 1'b1;
            atom       = 2'((k + 1) % 4);
            if (k < 15) exp_buf[2*k +: 2] = 2'((k + 1) % 4);
            else        exp_buf2[2*(k-15) +: 2] = 2'((k + 1) % 4);
            step();
        end
        atom_valid = 1'b0;
        #1;
        chk("bp_valid", 64'(frame_valid), 64'd1);
        chk("bp_hold_data", 64'(frame_data), {30'd0, 4'd15, exp_buf});
        chk("bp_count", 64'(dct_count), 64'd15);
        chk("bp_atom_ready", 64'(atom_ready), 64'd0);
        chk("bp_no_overflow", 64'(overflow), 64'd0);

        // Overflow when offering into a full, blocked buffer
        atom_valid = 1'b1;
        atom       = 2'd3;
        step();
        atom_valid = 1'b0;
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(dct_count), 64'd15);
        chk("ovf_hold_data", 64'(frame_data), {30'd0, 4'd15, exp_buf});

        // Slot frees: second frame loads on the same edge
        frame_ready = 1'b1;
        step();
        chk("bp2_valid", 64'(frame_valid), 64'd1);
        chk("bp2_data", 64'(frame_data), {30'd0, 4'd15, exp_buf2});
        chk("bp2_count", 64'(dct_count), 64'd0);
        chk("bp2_atom_ready", 64'(atom_ready), 64'd1);
        step();
        chk("bp2_handshake", 64'(frame_valid), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Asynchronous reset with a held frame and 7 buffered atoms
        frame_ready = 1'b0;
        atom_valid  = 1'b1;
        atom        = 2'd1;
        flush       = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 7; k++) begin
            atom = 2'(k % 4);
            step();
        end
        atom_valid = 1'b0;
        chk("pre_rst_valid", 64'(frame_valid), 64'd1);
        chk("pre_rst_count", 64'(dct_count), 64'd7);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(frame_valid), 64'd0);
        chk("arst_data", 64'(frame_data), 64'd0);
        chk("arst_count", 64'(dct_count), 64'd0);
        chk("arst_buffer", 64'(dct_buffer), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        chk("arst_atom_ready", 64'(atom_ready), 64'd1);
        #1;
        reset_n     = 1'b1;
        frame_ready = 1'b1;
        step();

        // End-of-test drain with 5 buffered atoms
        exp_buf = '0;
        for (int k = 0; k < 5; k++) begin
            atom_valid = 1'b1;
            atom       = 2'((k + 3) % 4);
            exp_buf[2*k +: 2] = 2'((k + 3) % 4);
            step();
        end
        atom_valid  = 1'b0;
        test_ending = 1'b1;
        step();
        test_ending = 1'b0;
        atom_valid  = 1'b1;
        atom        = 2'd2;
        #1;
        chk("drain_atom_ready", 64'(atom_ready), 64'd0);
        step();
        chk("drain_valid", 64'(frame_valid), 64'd1);
        chk("drain_data", 64'(frame_data), {30'd0, 4'd5, exp_buf});
        chk("drain_count", 64'(dct_count), 64'd0);
        chk("drain_not_ended", 64'(test_has_ended), 64'd0);
        step();
        chk("drain_handshake", 64'(frame_valid), 64'd0);
        chk("drain_ended_early", 64'(test_has_ended), 64'd0);
        step();
        chk("drain_ended", 64'(test_has_ended), 64'd1);
        chk("drain_no_overflow", 64'(overflow), 64'd0);
        chk("done_count", 64'(dct_count), 64'd0);
        step();
        atom_valid = 1'b0;
        chk("done_hold", 64'(test_has_ended), 64'd1);
        chk("done_atom_ready", 64'(atom_ready), 64'd0);
        chk("done_no_frame", 64'(frame_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
